// File: rtl/param_bus_proc.sv
// param_bus_proc: multi-cycle bus processor built around one shared internal bus.
// It holds NREG general registers, an accumulator (a) and a result register (g).
// An instruction is fetched from DIN when Run is seen in IDLE.
// mv, mvi and illegal opcodes complete in T1.
// ALU ops (add, sub, and, or) take T1 (load a), T2 (compute g and the flags)
// and T3 (write g back to Rx).
// DW must be at least 3 + 2*RW so that the whole instruction word fits in DIN.
module param_bus_proc #(
   parameter int DW   = 16,
   parameter int NREG = 8
) (
   input  logic          clk,
   input  logic          Resetn,
   input  logic          Run,
   input  logic [DW-1:0] DIN,
   output logic [DW-1:0] bus,
   output logic          Done,
   output logic          Busy,
   output logic          Err,
   output logic          Z,
   output logic          C
);

   localparam int RW = $clog2(NREG);
   localparam int IW = 3 + 2*RW;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;

   typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

   state_t         state, state_nxt;
   logic [IW-1:0]  ir;
   logic [2:0]     op;
   logic [RW-1:0]  rx_idx, ry_idx;
   logic [DW-1:0]  regs [NREG];
   logic [DW-1:0]  a, g;
   logic           rx_we, a_we, g_we;
   logic [DW:0]    alu_res;

   // ALU: result in the low DW bits, carry/borrow in bit DW
   function automatic logic [DW:0] alu(input logic [2:0] f,
                                       input logic [DW-1:0] x,
                                       input logic [DW-1:0] y);
      case (f)
         OP_ADD:  alu = {1'b0, x} + {1'b0, y};
         // the extra top bit of the difference is set exactly when x < y
         OP_SUB:  alu = {1'b0, x} - {1'b0, y};
         OP_AND:  alu = {1'b0, x & y};
         OP_OR:   alu = {1'b0, x | y};
         default: alu = '0;
      endcase
   endfunction

   assign op     = ir[IW-1 -: 3];
   assign rx_idx = ir[2*RW-1 -: RW];
   assign ry_idx = ir[RW-1:0];
   assign Busy   = (state != IDLE);

   // Next-state and bus-driver decode; Done/Err are pure decodes of state and ir
   always_comb begin
      state_nxt = state;
      bus       = '0;
      Done      = 1'b0;
      Err       = 1'b0;
      rx_we     = 1'b0;
      a_we      = 1'b0;
      g_we      = 1'b0;
      case (state)
         IDLE: begin
            if (Run) state_nxt = T1;
         end
         T1: begin
            case (op)
               OP_MV: begin
                  bus       = regs[ry_idx];
                  rx_we     = 1'b1;
                  Done      = 1'b1;
                  state_nxt = IDLE;
               end
               OP_MVI: begin
                  bus       = DIN;
                  rx_we     = 1'b1;
                  Done      = 1'b1;
                  state_nxt = IDLE;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  bus       = regs[rx_idx];
                  a_we      = 1'b1;
                  state_nxt = T2;
               end
               default: begin
                  Done      = 1'b1;
                  Err       = 1'b1;
                  state_nxt = IDLE;
               end
            endcase
         end
         T2: begin
            bus       = regs[ry_idx];
            g_we      = 1'b1;
            state_nxt = T3;
         end
         T3: begin
            bus       = g;
            rx_we     = 1'b1;
            Done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign alu_res = alu(op, a, bus);

   // State register; reset abandons any in-flight instruction
   always_ff @(posedge clk) begin
      if (!Resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Instruction register, loaded only on an accepted Run in IDLE
   always_ff @(posedge clk) begin
      if (!Resetn)                    ir <= '0;
      else if (state == IDLE && Run)  ir <= DIN[DW-1 -: IW];
   end

   // General registers, written from the bus (Ry, DIN or g)
   always_ff @(posedge clk) begin
      if (!Resetn) begin
         for (int k = 0; k < NREG; k++) regs[k] <= '0;
      end else if (rx_we) begin
         regs[rx_idx] <= bus;
      end
   end

   // Accumulator, result register and flags
   always_ff @(posedge clk) begin
      if (!Resetn) begin
         a <= '0;
         g <= '0;
         Z <= 1'b0;
         C <= 1'b0;
      end else begin
         if (a_we) a <= bus;
         if (g_we) begin
            g <= alu_res[DW-1:0];
            C <= alu_res[DW];
            Z <= (alu_res[DW-1:0] == '0);
         end
      end
   end

endmodule

// File: tb/tb_param_bus_proc.sv
// Bench for param_bus_proc: directed vector table, hand-written reset and
// Run-held sequences, then randomized instructions checked against a model.
module tb_param_bus_proc;
   localparam int DW   = 16;
   localparam int NREG = 8;
   localparam int RW   = 3;
   localparam int MOD  = 1 << DW;

   logic          clk = 1'b0;
   logic          Resetn, Run;
   logic [DW-1:0] DIN, bus;
   logic          Done, Busy, Err, Z, C;

   int checks = 0;
   int errors = 0;

   param_bus_proc #(.DW(DW), .NREG(NREG)) dut (
      .clk(clk), .Resetn(Resetn), .Run(Run), .DIN(DIN), .bus(bus),
      .Done(Done), .Busy(Busy), .Err(Err), .Z(Z), .C(C)
   );

   always #5 clk = ~clk;

   // Reference model state
   int m_reg [NREG];
   int m_z, m_c;

   typedef struct {
      int instr; int imm; int e_bus; int e_z; int e_c; int e_err; int e_lat;
   } vec_t;

   vec_t tbl [17] = '{
      '{'h2000, 'h0005, 'h0005, 0, 0, 0, 1},
      '{'h0400, 'h0000, 'h0005, 0, 0, 0, 1},
      '{'h4080, 'h0000, 'h000A, 0, 0, 0, 3},
      '{'h6400, 'h0000, 'hFFFB, 0, 1, 0, 3},
      '{'h0480, 'h0000, 'hFFFB, 0, 1, 0, 1},
      '{'h6000, 'h0000, 'h0000, 1, 0, 0, 3},
      '{'hE000, 'h0000, 'h0000, 1, 0, 1, 1},
      '{'h2800, 'hFFFF, 'hFFFF, 1, 0, 0, 1},
      '{'h4880, 'h0000, 'hFFFA, 0, 1, 0, 3},
      '{'h2C00, 'h0001, 'h0001, 0, 1, 0, 1},
      '{'h3000, 'hFFFF, 'hFFFF, 0, 1, 0, 1},
      '{'h5180, 'h0000, 'h0000, 1, 1, 0, 3},
      '{'h8980, 'h0000, 'h0000, 1, 0, 0, 3},
      '{'hA880, 'h0000, 'hFFFB, 0, 0, 0, 3},
      '{'hF000, 'h0000, 'h0000, 0, 0, 1, 1},
      '{'h4900, 'h0000, 'hFFF6, 0, 1, 0, 3},
      '{'h0100, 'h0000, 'hFFF6, 0, 1, 0, 1}
   };

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] enc(input int op, input int x, input int y);
      return DW'((op * (1 << (2*RW)) + x * (1 << RW) + y) * (1 << (DW - 3 - 2*RW)));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NREG; k++) m_reg[k] = 0;
      m_z = 0;
      m_c = 0;
   endtask

   // Instruction semantics written directly from the opcode table
   task automatic model_exec(input int op, input int x, input int y, input int imm,
                             output int e_bus, output int e_lat, output int e_err);
      int va, vb, res;
      va = m_reg[x];
      vb = m_reg[y];
      e_bus = 0; e_lat = 1; e_err = 0;
      if (op == 0) begin
         m_reg[x] = vb; e_bus = vb;
      end else if (op == 1) begin
         m_reg[x] = imm; e_bus = imm;
      end else if (op >= 2 && op <= 5) begin
         if (op == 2)      begin res = va + vb; m_c = (res >= MOD) ? 1 : 0; end
         else if (op == 3) begin res = va - vb + MOD; m_c = (va < vb) ? 1 : 0; end
         else if (op == 4) begin res = va & vb; m_c = 0; end
         else              begin res = va | vb; m_c = 0; end
         res = res % MOD;
         m_z = (res == 0) ? 1 : 0;
         m_reg[x] = res;
         e_bus = res;
         e_lat = 3;
      end else begin
         e_err = 1;
      end
   endtask

   // Issue one instruction, return when Done is seen (bounded) in the Done cycle
   task automatic dut_exec(input logic [DW-1:0] instr, input logic [DW-1:0] imm,
                           output int lat, output logic [DW-1:0] dbus,
                           output logic derr, output int busy_cnt);
      bit seen;
      seen = 0;
      @(negedge clk); Run = 1'b1; DIN = instr;
      @(negedge clk); Run = 1'b0; DIN = imm;
      lat = 0; busy_cnt = 0; dbus = '0; derr = 1'b0;
      for (int i = 1; i <= 8 && !seen; i++) begin
         #1;
         if (Busy) busy_cnt++;
         if (Done) begin
            seen = 1; lat = i; dbus = bus; derr = Err;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic do_instr(input string name, input int op, input int x, input int y,
                           input int imm, input int junk);
      int e_bus, e_lat, e_err, lat, bcnt;
      logic [DW-1:0] dbus;
      logic derr;
      model_exec(op, x, y, imm, e_bus, e_lat, e_err);
      dut_exec(enc(op, x, y) | DW'(junk), DW'(imm), lat, dbus, derr, bcnt);
      check({name, "_lat"},  lat,  e_lat);
      check({name, "_bus"},  dbus, e_bus);
      check({name, "_err"},  derr, e_err);
      check({name, "_busy"}, bcnt, e_lat);
      check({name, "_z"},    Z,    m_z);
      check({name, "_c"},    C,    m_c);
   endtask

   task automatic readback_all(input string name);
      for (int k = 0; k < NREG; k++) do_instr($sformatf("%s_r%0d", name, k), 0, k, k, 0, 0);
   endtask

   initial begin
      int lat, bcnt, e_bus, e_lat, e_err;
      logic [DW-1:0] dbus;
      logic derr;
      logic [4:0] bh, dh;
      int op, x, y, imm, sel;

      Resetn = 1'b0; Run = 1'b0; DIN = '0;
      repeat (2) @(negedge clk);
      Resetn = 1'b1;
      model_reset();
      #1;
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_err",  Err,  0);
      check("rst_bus",  bus,  0);
      check("rst_z",    Z,    0);
      check("rst_c",    C,    0);
      readback_all("rst");

      // Directed table
      for (int i = 0; i < 17; i++) begin
         logic [DW-1:0] w;
         w = DW'(tbl[i].instr);
         model_exec(int'(w[15:13]), int'(w[12:10]), int'(w[9:7]), tbl[i].imm,
                    e_bus, e_lat, e_err);
         dut_exec(w, DW'(tbl[i].imm), lat, dbus, derr, bcnt);
         check($sformatf("tbl%0d_lat", i),  lat,  tbl[i].e_lat);
         check($sformatf("tbl%0d_bus", i),  dbus, tbl[i].e_bus);
         check($sformatf("tbl%0d_err", i),  derr, tbl[i].e_err);
         check($sformatf("tbl%0d_busy", i), bcnt, tbl[i].e_lat);
         check($sformatf("tbl%0d_z", i),    Z,    tbl[i].e_z);
         check($sformatf("tbl%0d_c", i),    C,    tbl[i].e_c);
         @(negedge clk); #1;
         check($sformatf("tbl%0d_idle_busy", i), Busy, 0);
         check($sformatf("tbl%0d_idle_done", i), Done, 0);
      end
      readback_all("tbl");

      // Reset in the middle of an add
      @(negedge clk); Run = 1'b1; DIN = 16'h4080;
      @(negedge clk); Run = 1'b0;
      @(negedge clk); #1;
      check("midrst_t2_busy", Busy, 1);
      Resetn = 1'b0;
      @(negedge clk); #1;
      check("midrst_busy", Busy, 0);
      check("midrst_done", Done, 0);
      check("midrst_err",  Err,  0);
      check("midrst_bus",  bus,  0);
      check("midrst_z",    Z,    0);
      check("midrst_c",    C,    0);
      Resetn = 1'b1;
      model_reset();
      readback_all("midrst");

      // Run held high: no fetch in the Done cycle, next accept in the following IDLE cycle
      @(negedge clk); Run = 1'b1; DIN = 16'h4080;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         bh[4-i] = Busy;
         dh[4-i] = Done;
      end
      Run = 1'b0;
      check("held_busy", bh, 5'b11101);
      check("held_done", dh, 5'b00100);
      lat = 0;
      for (int i = 1; i <= 6 && lat == 0; i++) begin
         @(negedge clk); #1;
         if (Done) lat = i;
      end
      check("held_2nd_lat", lat, 2);
      model_exec(2, 0, 1, 0, e_bus, e_lat, e_err);
      model_exec(2, 0, 1, 0, e_bus, e_lat, e_err);
      check("held_z", Z, m_z);
      check("held_c", C, m_c);

      // Randomized instructions against the model
      for (int i = 0; i < 300; i++) begin
         op  = int'($urandom_range(0, 7));
         x   = int'($urandom_range(0, NREG-1));
         y   = int'($urandom_range(0, NREG-1));
         sel = int'($urandom_range(0, 3));
         imm = (sel == 0) ? 0 : (sel == 1) ? MOD-1 : int'($urandom_range(0, MOD-1));
         do_instr($sformatf("rnd%0d", i), op, x, y, imm, int'($urandom_range(0, 127)));
      end
      readback_all("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
